// File: rtl/ddr_ui_burst_bridge_if.sv
// ddr_ui_burst_bridge_if: UI command/data, DDR FIFO and burst-engine signals of the bridge.
interface ddr_ui_burst_bridge_if #(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 29,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int LEN_WIDTH       = 16
);
   logic                       ui_cmd_valid, ui_cmd_ready, ui_cmd_rw;
   logic [ADDR_WIDTH-1:0]      ui_cmd_addr;
   logic [LEN_WIDTH-1:0]       ui_cmd_len;
   logic                       ui_wr_valid, ui_wr_ready;
   logic [DATA_WIDTH-1:0]      ui_wr_data;
   logic                       ui_rd_valid, ui_rd_ready;
   logic [DATA_WIDTH-1:0]      ui_rd_data;
   logic                       ui_done, ui_busy;
   logic                       wr_fifo_wr_en, wr_fifo_full;
   logic [DATA_WIDTH-1:0]      wr_fifo_wr_data;
   logic                       rd_fifo_rd_en, rd_fifo_empty;
   logic [DATA_WIDTH-1:0]      rd_fifo_rd_data;
   logic                       rd_start, wr_start;
   logic [BURST_LEN_WIDTH-1:0] rd_burst_len, wr_burst_len;
   logic [ADDR_WIDTH-1:0]      rd_start_addr, wr_start_addr;
   logic                       rd_ready, wr_ready, rd_done, wr_done;

   modport slave (
      input  ui_cmd_valid, ui_cmd_rw, ui_cmd_addr, ui_cmd_len, ui_wr_valid, ui_wr_data, ui_rd_ready,
             wr_fifo_full, rd_fifo_rd_data, rd_fifo_empty, rd_ready, wr_ready, rd_done, wr_done,
      output ui_cmd_ready, ui_wr_ready, ui_rd_valid, ui_rd_data, ui_done, ui_busy,
             wr_fifo_wr_en, wr_fifo_wr_data, rd_fifo_rd_en, rd_start, wr_start,
             rd_burst_len, wr_burst_len, rd_start_addr, wr_start_addr
   );

   modport master (
      output ui_cmd_valid, ui_cmd_rw, ui_cmd_addr, ui_cmd_len, ui_wr_valid, ui_wr_data, ui_rd_ready,
             wr_fifo_full, rd_fifo_rd_data, rd_fifo_empty, rd_ready, wr_ready, rd_done, wr_done,
      input  ui_cmd_ready, ui_wr_ready, ui_rd_valid, ui_rd_data, ui_done, ui_busy,
             wr_fifo_wr_en, wr_fifo_wr_data, rd_fifo_rd_en, rd_start, wr_start,
             rd_burst_len, wr_burst_len, rd_start_addr, wr_start_addr
   );
endinterface

// File: rtl/ddr_ui_burst_bridge.sv
// ddr_ui_burst_bridge: splits UI commands into DDR bursts and moves data through the rd/wr FIFOs.
// Define DDR_BRIDGE_4K_SPLIT_EN to keep every burst inside one 4 KB page.
module ddr_ui_burst_bridge #(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 29,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_BURST       = 64,
   parameter int RD_FIFO_DEPTH   = 512
) (
   input logic                    clk,
   input logic                    rst,
   ddr_ui_burst_bridge_if.slave   io_bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam int CW    = LEN_WIDTH + 1;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_DRAIN, S_FIN} state_t;

   state_t                     r_state, w_next;
   logic                       r_rw, r_start, r_done, r_wp, r_rp, r_inflight;
   logic [ADDR_WIDTH-1:0]      r_addr, r_saddr;
   logic [CW-1:0]              r_len, r_rem, r_beats, r_pushed, r_issued, r_popped, r_given;
   logic [BURST_LEN_WIDTH-1:0] r_blen;
   logic [DATA_WIDTH-1:0]      r_buf [2];
   logic [1:0]                 r_cnt;
   logic                       w_accept, w_wr_act, w_rd_act, w_push, w_pop, w_rd_en;
   logic                       w_eng_ready, w_eng_done, w_can_issue, w_issue;
   logic [CW-1:0]              w_beats;
`ifdef DDR_BRIDGE_4K_SPLIT_EN
   logic [12:0]                w_lim4k;
   assign w_lim4k = (13'h1000 - {1'b0, r_addr[11:0]}) >> BSH;
`endif

   assign io_bus.ui_cmd_ready    = (r_state == S_IDLE) && !rst;
   assign io_bus.ui_busy         = r_state != S_IDLE;
   assign io_bus.ui_done         = r_done;
   assign w_accept               = io_bus.ui_cmd_valid && io_bus.ui_cmd_ready;
   assign w_wr_act               = r_rw && r_state != S_IDLE;
   assign w_rd_act               = !r_rw && r_state != S_IDLE;
   assign io_bus.ui_wr_ready     = w_wr_act && !io_bus.wr_fifo_full && r_pushed < r_len;
   assign w_push                 = io_bus.ui_wr_valid && io_bus.ui_wr_ready;
   assign io_bus.wr_fifo_wr_en   = w_push;
   assign io_bus.wr_fifo_wr_data = io_bus.ui_wr_data;
   assign io_bus.ui_rd_valid     = r_cnt != 2'd0;
   assign io_bus.ui_rd_data      = r_buf[r_rp];
   assign w_pop                  = io_bus.ui_rd_valid && io_bus.ui_rd_ready;
   // Counting this cycle's pop as free space keeps reads at one beat per cycle.
   assign w_rd_en                = w_rd_act && !io_bus.rd_fifo_empty && r_popped < r_len &&
                                   ({1'b0, r_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
   assign io_bus.rd_fifo_rd_en   = w_rd_en;
   assign io_bus.rd_start        = r_start && !r_rw;
   assign io_bus.wr_start        = r_start && r_rw;
   assign io_bus.rd_burst_len    = r_blen;
   assign io_bus.wr_burst_len    = r_blen;
   assign io_bus.rd_start_addr   = r_saddr;
   assign io_bus.wr_start_addr   = r_saddr;
   assign w_eng_ready            = r_rw ? io_bus.wr_ready : io_bus.rd_ready;
   assign w_eng_done             = r_rw ? io_bus.wr_done : io_bus.rd_done;
   assign w_can_issue            = r_rw ? (r_pushed - r_issued >= r_beats)
                                        : (32'(r_issued - r_popped) + 32'(r_beats) <= RD_FIFO_DEPTH);
   assign w_issue                = r_state == S_ISSUE && w_eng_ready && w_can_issue;

   always_comb begin
      w_beats = (r_rem < CW'(MAX_BURST)) ? r_rem : CW'(MAX_BURST);
`ifdef DDR_BRIDGE_4K_SPLIT_EN
      w_beats = (w_beats < CW'(w_lim4k)) ? w_beats : CW'(w_lim4k);
`endif
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_accept ? ((io_bus.ui_cmd_len == '0) ? S_FIN : S_CALC) : S_IDLE;
         S_CALC:  w_next = S_ISSUE;
         S_ISSUE: w_next = w_issue ? S_WAIT : S_ISSUE;
         S_WAIT:  w_next = !w_eng_done ? S_WAIT : (r_rem != '0) ? S_CALC : r_rw ? S_FIN : S_DRAIN;
         S_DRAIN: w_next = (r_given == r_len) ? S_FIN : S_DRAIN;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_rw     <= 1'b0;
         r_start  <= 1'b0;
         r_done   <= 1'b0;
         r_addr   <= '0;
         r_saddr  <= '0;
         r_blen   <= '0;
         r_len    <= '0;
         r_rem    <= '0;
         r_beats  <= '0;
         r_pushed <= '0;
         r_issued <= '0;
         r_popped <= '0;
         r_given  <= '0;
      end else begin
         r_state <= w_next;
         r_start <= w_issue;
         r_done  <= r_state == S_FIN;
         if (w_accept) begin
            r_rw     <= io_bus.ui_cmd_rw;
            r_addr   <= io_bus.ui_cmd_addr;
            r_len    <= {1'b0, io_bus.ui_cmd_len};
            r_rem    <= {1'b0, io_bus.ui_cmd_len};
            r_pushed <= '0;
            r_issued <= '0;
            r_popped <= '0;
            r_given  <= '0;
         end else begin
            if (w_push) r_pushed <= r_pushed + 1'b1;
            if (w_rd_en) r_popped <= r_popped + 1'b1;
            if (w_pop) r_given <= r_given + 1'b1;
            if (w_issue) r_issued <= r_issued + r_beats;
         end
         if (r_state == S_CALC) r_beats <= w_beats;
         if (w_issue) begin
            r_blen  <= BURST_LEN_WIDTH'(r_beats - 1'b1);
            r_saddr <= r_addr;
            r_addr  <= r_addr + (ADDR_WIDTH'(r_beats) << BSH);
            r_rem   <= r_rem - r_beats;
         end
      end
   end

   // FIFO read data lands one cycle after rd_en; r_inflight tracks that beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_inflight <= 1'b0;
         r_cnt      <= 2'd0;
      end else begin
         r_inflight <= w_rd_en;
         if (r_inflight) begin
            r_buf[r_wp] <= io_bus.rd_fifo_rd_data;
            r_wp        <= !r_wp;
         end
         if (w_pop) r_rp <= !r_rp;
         r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end
endmodule
